vga_tile_wr_dma: RTL

//  Parametrised video-memory write-address generator for the VGA frame buffer.
//  The frame buffer is a grid of TILES_X x TILES_Y image tiles, each IMG_W x IMG_H pixels.

---
 rtl/vga_tile_wr_dma_pkg.sv | 24 ++
 rtl/vga_tile_wr_dma_if.sv | 26 ++
 rtl/vga_tile_wr_dma_base.sv | 31 +++
 rtl/vga_tile_wr_dma.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/vga_tile_wr_dma_pkg.sv
// Shared types and helpers for the VGA tile write-address generator.
package vga_tile_wr_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam int DROP_W = 16;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clamp_i(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic int clog2_min1(input int v);
        return max_i(1, $clog2(v));
    endfunction

endpackage

// File: rtl/vga_tile_wr_dma_if.sv
// Pixel-strobe in / frame-buffer write out bundle.
interface vga_tile_wr_dma_if #(
    parameter int AW = 17
);
    import vga_tile_wr_dma_pkg::*;

    logic          we_in;
    logic          done;
    logic [AW-1:0] waddr;
    logic          we_out;

    modport master (
        output we_in,
        output done,
        input  waddr,
        input  we_out
    );

    modport slave (
        input  we_in,
        input  done,
        output waddr,
        output we_out
    );

endinterface

// File: rtl/vga_tile_wr_dma_base.sv
// Tile index to frame-buffer base address, constant multiplies only.
module vga_tile_base
    import vga_tile_wr_dma_pkg::*;
#(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int TILES_X = 2,
    parameter int TILES_Y = 1,
    localparam int FB_W = IMG_W * TILES_X,
    localparam int NT   = TILES_X * TILES_Y,
    localparam int AW   = $clog2(FB_W * IMG_H * TILES_Y),
    localparam int TW   = clog2_min1(NT)
) (
    input  logic [TW-1:0] idx,
    output logic [AW-1:0] base
);

    localparam logic [AW-1:0] TX   = AW'(TILES_X);
    localparam logic [AW-1:0] XSTP = AW'(IMG_W);
    localparam logic [AW-1:0] YSTP = AW'(IMG_H * FB_W);

    logic [AW-1:0] idx_w;
    logic [AW-1:0] tx;
    logic [AW-1:0] ty;

    assign idx_w = AW'(idx);
    assign tx    = idx_w % TX;
    assign ty    = idx_w / TX;
    assign base  = (tx * XSTP) + (ty * YSTP);

endmodule

// File: rtl/vga_tile_wr_dma.sv
// Frame-buffer write-address generator: tile select, raster counters, drops.
module vga_tile_wr_dma
    import vga_tile_wr_dma_pkg::*;
#(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int TILES_X = 2,
    parameter int TILES_Y = 1,
    parameter int WRAP    = 0,
    localparam int FB_W = IMG_W * TILES_X,
    localparam int NT   = TILES_X * TILES_Y,
    localparam int AW   = $clog2(FB_W * IMG_H * TILES_Y),
    localparam int TW   = clog2_min1(NT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              auto_mode,
    input  logic [TW-1:0]     tile_sel,
    vga_tile_wr_dma_if.slave  bus,
    output logic              busy,
    output logic              frame_done,
    output logic [TW-1:0]     cur_tile,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int CW = clog2_min1(IMG_W);
    localparam int RW = clog2_min1(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_W - IMG_W + 1);
    localparam logic [TW-1:0] PTR_LAST = TW'(NT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] base;
    logic [TW-1:0] ptr_q;
    logic [TW-1:0] sel_c;
    logic [TW-1:0] idx;
    logic          acc;
    logic          col_end;
    logic          last_pix;
    logic          step;
    logic          drop;

    assign sel_c = TW'(clamp_i(int'(tile_sel), NT - 1));
    assign idx   = auto_mode ? ptr_q : sel_c;

    vga_tile_base #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .TILES_X (TILES_X),
        .TILES_Y (TILES_Y)
    ) u_base (
        .idx  (idx),
        .base (base)
    );

    // A start in the same cycle wins over the pixel strobe.
    assign acc      = bus.we_in & (state_q == ST_RUN) & ~start;
    assign col_end  = (col_q == COL_LAST);
    assign last_pix = acc & col_end & (row_q == ROW_LAST);
    assign step     = acc & ~last_pix;
    assign drop     = bus.we_in & ~acc;

    assign bus.we_out = acc;
    assign bus.waddr  = waddr_q;
    assign busy       = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            start:    state_d = ST_RUN;
            last_pix: state_d = ST_FULL;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cur_tile   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_pix;
            unique case (1'b1)
                start: begin
                    waddr_q  <= base;
                    col_q    <= '0;
                    row_q    <= '0;
                    cur_tile <= idx;
                end
                step: begin
                    if (col_end) begin
                        col_q   <= '0;
                        row_q   <= row_q + 1'b1;
                        waddr_q <= waddr_q + ROW_STEP;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        waddr_q <= waddr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer for the next auto-selected frame; start samples the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if ((NT > 1) && bus.done) begin
            if (ptr_q == PTR_LAST) begin
                ptr_q <= (WRAP != 0) ? '0 : PTR_LAST;
            end else begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
